pcie_app_rst_seq: RTL and testbench

- Application-side consumer of the PCIe HIP reset outputs (application reset, active-low; configuration reset, active-high).
- Releases the application sub-blocks from reset in an ordered, staggered sequence: DMA, register file, link engines, stats.
- On a new application-reset request while running, asks the sub-blocks to quiesce, waits for their acks or a timeout, then asserts their resets together.
- Sits in the application layer between the HIP reset block and the application datapath.

---
 rtl/pcie_rst_pkg.sv | 21 ++
 rtl/rst_stage_shifter.sv | 51 +++++
 rtl/pcie_app_rst_seq.sv | 132 +++++++++++++
 tb/tb_pcie_app_rst_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pcie_rst_pkg.sv
// rtl/pcie_rst_pkg.sv - shared types and defaults for the PCIe application reset sequencer
package pcie_rst_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_APP,
        ST_RELEASE,
        ST_RUN,
        ST_QUIESCE,
        ST_ASSERT
    } rst_seq_state_t;

    localparam int PCIE_RST_STAGES      = 4;
    localparam int PCIE_RST_STAGE_DLY   = 16;
    localparam int PCIE_RST_QUIESCE_TMO = 1024;

    localparam int RST_STG_DMA  = 0;
    localparam int RST_STG_REG  = 1;
    localparam int RST_STG_LNK  = 2;
    localparam int RST_STG_STAT = 3;

endpackage

// File: rtl/rst_stage_shifter.sv
// rtl/rst_stage_shifter.sv - staggered per-stage reset release vector
module rst_stage_shifter
    import pcie_rst_pkg::*;
#(
    parameter int NUM_STAGES = PCIE_RST_STAGES,
    parameter int STAGE_DLY  = PCIE_RST_STAGE_DLY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  adv,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  last_fire
);

    localparam int CNT_W = $clog2(STAGE_DLY + 1);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             fire;

    // A stage is released on the first cycle of each STAGE_DLY window.
    assign fire      = adv && (cnt == '0) && (idx < IDX_W'(NUM_STAGES));
    assign last_fire = fire && (idx == IDX_W'(NUM_STAGES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            stage_rst_n <= '0;
        end else if (clr) begin
            cnt         <= '0;
            idx         <= '0;
            stage_rst_n <= '0;
        end else if (adv) begin
            if (fire) begin
                stage_rst_n <= stage_rst_n | (NUM_STAGES'(1) << idx);
            end
            if (cnt == CNT_W'(STAGE_DLY - 1)) begin
                cnt <= '0;
                if (idx < IDX_W'(NUM_STAGES)) begin
                    idx <= idx + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_app_rst_seq.sv
// rtl/pcie_app_rst_seq.sv - ordered release and quiesced re-assert of application sub-block resets
module pcie_app_rst_seq
    import pcie_rst_pkg::*;
#(
    parameter int NUM_STAGES  = PCIE_RST_STAGES,
    parameter int STAGE_DLY   = PCIE_RST_STAGE_DLY,
    parameter int QUIESCE_TMO = PCIE_RST_QUIESCE_TMO,
    parameter int MIN_ASSERT  = 8
) (
    input  logic                  iPLD_CLK,
    input  logic                  iNPOR_n,
    input  logic                  iAPP_RST_n,
    input  logic                  iCRST,
    input  logic [NUM_STAGES-1:0] iQUIESCE_ACK,
    input  logic                  iSTS_CLR,
    output logic [NUM_STAGES-1:0] oSTAGE_RST_n,
    output logic                  oCFG_RST,
    output logic                  oQUIESCE_REQ,
    output logic                  oRST_DONE,
    output logic                  oTIMEOUT_STS
);

    localparam int TMR_W = $clog2(QUIESCE_TMO + 1);
    localparam int HLD_W = $clog2(MIN_ASSERT + 1);

    rst_seq_state_t          state;
    logic                    app_r;
    logic                    crst_r;
    logic [NUM_STAGES-1:0]   ack_r;
    logic [TMR_W-1:0]        tmr;
    logic [HLD_W-1:0]        hcnt;
    logic                    all_ack;
    logic                    tmo_hit;
    logic                    q_exit;
    logic                    shf_clr;
    logic                    shf_adv;
    logic                    last_fire;

    always_ff @(posedge iPLD_CLK or negedge iNPOR_n) begin
        if (!iNPOR_n) begin
            app_r    <= 1'b0;
            crst_r   <= 1'b1;
            ack_r    <= '0;
            oCFG_RST <= 1'b1;
        end else begin
            app_r    <= iAPP_RST_n;
            crst_r   <= iCRST;
            ack_r    <= iQUIESCE_ACK;
            oCFG_RST <= crst_r;
        end
    end

    assign all_ack = &ack_r;
    assign tmo_hit = (tmr == TMR_W'(QUIESCE_TMO - 1));
    assign q_exit  = (state == ST_QUIESCE) && (all_ack || tmo_hit);
    // Aborting a release skips quiesce: the stages are simply pulled back into reset.
    assign shf_clr = (state == ST_WAIT_APP) || ((state == ST_RELEASE) && !app_r) || q_exit;
    assign shf_adv = (state == ST_RELEASE) && app_r;

    rst_stage_shifter #(
        .NUM_STAGES (NUM_STAGES),
        .STAGE_DLY  (STAGE_DLY)
    ) u_shifter (
        .clk         (iPLD_CLK),
        .rst_n       (iNPOR_n),
        .clr         (shf_clr),
        .adv         (shf_adv),
        .stage_rst_n (oSTAGE_RST_n),
        .last_fire   (last_fire)
    );

    always_ff @(posedge iPLD_CLK or negedge iNPOR_n) begin
        if (!iNPOR_n) begin
            state        <= ST_WAIT_APP;
            tmr          <= '0;
            hcnt         <= '0;
            oQUIESCE_REQ <= 1'b0;
            oRST_DONE    <= 1'b0;
            oTIMEOUT_STS <= 1'b0;
        end else begin
            // A timeout in the same cycle as a clear overrides it below.
            if (iSTS_CLR) begin
                oTIMEOUT_STS <= 1'b0;
            end
            case (state)
                ST_WAIT_APP: begin
                    oRST_DONE <= 1'b0;
                    if (app_r) begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!app_r) begin
                        state <= ST_WAIT_APP;
                    end else if (last_fire) begin
                        oRST_DONE <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!app_r) begin
                        state        <= ST_QUIESCE;
                        oQUIESCE_REQ <= 1'b1;
                        tmr          <= '0;
                    end
                end
                ST_QUIESCE: begin
                    if (q_exit) begin
                        state        <= ST_ASSERT;
                        oQUIESCE_REQ <= 1'b0;
                        oRST_DONE    <= 1'b0;
                        hcnt         <= '0;
                        if (!all_ack) begin
                            oTIMEOUT_STS <= 1'b1;
                        end
                    end else if (tmr != TMR_W'(QUIESCE_TMO)) begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (hcnt == HLD_W'(MIN_ASSERT - 1)) begin
                        state <= ST_WAIT_APP;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: state <= ST_WAIT_APP;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_app_rst_seq.sv
// tb/tb_pcie_app_rst_seq.sv - directed table-driven bench for pcie_app_rst_seq
module tb_pcie_app_rst_seq;

    logic       clk = 1'b0;
    logic       npor_n;
    logic       app_n;
    logic       crst;
    logic [3:0] ack;
    logic       sts_clr;
    logic [3:0] stage_rst_n;
    logic       cfg_rst;
    logic       qreq;
    logic       done;
    logic       tmo_sts;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         n;
        logic       app;
        logic       crst;
        logic       clr;
        logic [3:0] ack;
        logic [3:0] s;
        logic       q;
        logic       d;
        logic       t;
        logic       c;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    pcie_app_rst_seq dut (
        .iPLD_CLK     (clk),
        .iNPOR_n      (npor_n),
        .iAPP_RST_n   (app_n),
        .iCRST        (crst),
        .iQUIESCE_ACK (ack),
        .iSTS_CLR     (sts_clr),
        .oSTAGE_RST_n (stage_rst_n),
        .oCFG_RST     (cfg_rst),
        .oQUIESCE_REQ (qreq),
        .oRST_DONE    (done),
        .oTIMEOUT_STS (tmo_sts)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input logic a, input logic cr, input logic cl, input logic [3:0] ak,
                       input logic [3:0] s, input logic q, input logic d, input logic t, input logic c);
        vec_t v;
        v.n = n; v.app = a; v.crst = cr; v.clr = cl; v.ack = ak;
        v.s = s; v.q = q; v.d = d; v.t = t; v.c = c;
        tbl.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] s, input logic q, input logic d,
                           input logic t, input logic c);
        chk({tag, ".stage"}, stage_rst_n, s);
        chk({tag, ".qreq"}, {3'b0, qreq}, {3'b0, q});
        chk({tag, ".done"}, {3'b0, done}, {3'b0, d});
        chk({tag, ".tmo"}, {3'b0, tmo_sts}, {3'b0, t});
        chk({tag, ".cfg"}, {3'b0, cfg_rst}, {3'b0, c});
    endtask

    initial begin
        //   n    app crst clr ack    stage  q  d  t  c
        // power-up release, stage k at +3+16k
        add(2,    1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        add(1,    1, 1, 0, 4'h0, 4'h1, 0, 0, 0, 1);
        add(15,   1, 1, 0, 4'h0, 4'h1, 0, 0, 0, 1);
        add(1,    1, 1, 0, 4'h0, 4'h3, 0, 0, 0, 1);
        add(16,   1, 1, 0, 4'h0, 4'h7, 0, 0, 0, 1);
        add(15,   1, 1, 0, 4'h0, 4'h7, 0, 0, 0, 1);
        add(1,    1, 1, 0, 4'h0, 4'hF, 0, 1, 0, 1);
        // cfg reset latency, acks ignored in RUN
        add(1,    1, 0, 0, 4'hF, 4'hF, 0, 1, 0, 1);
        add(1,    1, 0, 0, 4'hF, 4'hF, 0, 1, 0, 0);
        add(2,    1, 1, 0, 4'hF, 4'hF, 0, 1, 0, 1);
        // clean quiesce
        add(1,    0, 1, 0, 4'h0, 4'hF, 0, 1, 0, 1);
        add(1,    0, 1, 0, 4'h0, 4'hF, 1, 1, 0, 1);
        add(18,   0, 1, 0, 4'h0, 4'hF, 1, 1, 0, 1);
        add(1,    0, 1, 0, 4'hF, 4'hF, 1, 1, 0, 1);
        add(1,    0, 1, 0, 4'hF, 4'h0, 0, 0, 0, 1);
        add(7,    0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        add(3,    0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        // release again, then timeout with ack stuck at 7
        add(2,    1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        add(1,    1, 1, 0, 4'h0, 4'h1, 0, 0, 0, 1);
        add(48,   1, 1, 0, 4'h0, 4'hF, 0, 1, 0, 1);
        add(2,    0, 1, 0, 4'h7, 4'hF, 1, 1, 0, 1);
        add(1023, 0, 1, 0, 4'h7, 4'hF, 1, 1, 0, 1);
        add(1,    0, 1, 0, 4'h7, 4'h0, 0, 0, 1, 1);
        add(8,    0, 1, 0, 4'h0, 4'h0, 0, 0, 1, 1);
        add(1,    0, 1, 1, 4'h0, 4'h0, 0, 0, 0, 1);
        add(1,    0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        // abort 20 cycles into release
        add(2,    1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        add(1,    1, 1, 0, 4'h0, 4'h1, 0, 0, 0, 1);
        add(16,   1, 1, 0, 4'h0, 4'h3, 0, 0, 0, 1);
        add(1,    0, 1, 0, 4'h0, 4'h3, 0, 0, 0, 1);
        add(1,    0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        add(5,    0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        // mid-quiesce recovery
        add(2,    1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        add(49,   1, 1, 0, 4'h0, 4'hF, 0, 1, 0, 1);
        add(2,    0, 1, 0, 4'h0, 4'hF, 1, 1, 0, 1);
        add(5,    1, 1, 0, 4'h0, 4'hF, 1, 1, 0, 1);
        add(2,    1, 1, 0, 4'hF, 4'h0, 0, 0, 0, 1);
        add(9,    1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
        add(1,    1, 1, 0, 4'h0, 4'h1, 0, 0, 0, 1);
        add(15,   1, 1, 0, 4'h0, 4'h1, 0, 0, 0, 1);
        add(1,    1, 1, 0, 4'h0, 4'h3, 0, 0, 0, 1);
        add(32,   1, 1, 0, 4'h0, 4'hF, 0, 1, 0, 1);

        npor_n = 1'b0; app_n = 1'b0; crst = 1'b1; ack = 4'h0; sts_clr = 1'b0;
        step(5);
        chk_all("reset", 4'h0, 0, 0, 0, 1);
        npor_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            app_n = tbl[i].app; crst = tbl[i].crst; sts_clr = tbl[i].clr; ack = tbl[i].ack;
            step(tbl[i].n);
            chk_all($sformatf("vec%0d", i), tbl[i].s, tbl[i].q, tbl[i].d, tbl[i].t, tbl[i].c);
        end

        // timeout coinciding with a status clear keeps the flag set
        app_n = 1'b0; ack = 4'h0;
        step(2);
        chk_all("clrtmo.q", 4'hF, 1, 1, 0, 1);
        step(1023);
        chk_all("clrtmo.pre", 4'hF, 1, 1, 0, 1);
        sts_clr = 1'b1;
        step(1);
        sts_clr = 1'b0;
        chk_all("clrtmo.hit", 4'h0, 0, 0, 1, 1);

        // back to RUN, then asynchronous reset between edges
        app_n = 1'b1;
        step(58);
        chk_all("rerun", 4'hF, 0, 1, 1, 1);
        crst = 1'b0;
        step(2);
        chk_all("cfg0", 4'hF, 0, 1, 1, 0);
        #3;
        npor_n = 1'b0;
        #1;
        chk_all("async", 4'h0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        npor_n = 1'b1;
        chk_all("async.hold", 4'h0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
